// File: rtl/udp_stream_arbiter.sv
// udp_stream_arbiter: packet-granular round-robin arbiter that merges N
// 16-bit AXI-stream UDP sources onto one output. The grant is held for a
// whole packet. Packets longer than MAX_BEATS are cut with a forced m_last,
// and the remainder of the source packet is drained. The block also keeps a
// forwarded-packet counter and a sticky oversize flag for the host.
module udp_stream_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      s_valid,
    output logic [N-1:0]      s_ready,
    input  logic [16*N-1:0]   s_data,
    input  logic [N-1:0]      s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       m_data,
    output logic              m_last,
    output logic [N-1:0]      grant,
    output logic              busy,
    output logic [15:0]       pkt_count,
    output logic              err_oversize
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [15:0]     pkt_count_q, pkt_count_d;
    logic            err_q, err_d;

    logic [15:0]     src_data [N];
    logic [15:0]     own_data;
    logic            own_valid;
    logic            own_last;
    logic            forced_last;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;

    // Unpack the flat source data bus and select the current owner's lane.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_data[i] = s_data[16*i +: 16];
        end
        own_data  = src_data[owner_q];
        own_valid = s_valid[owner_q];
        own_last  = s_last[owner_q];
    end

    // Round-robin pick: first requesting source after last_grant, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_grant_q) + k) % N);
            if (!pick_valid && s_valid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and output logic of the IDLE/XFER/DRAIN controller.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave a value held (no latches).
        state_d      = state_q;
        owner_d      = owner_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        pkt_count_d  = pkt_count_q;
        err_d        = err_q;
        s_ready      = '0;
        m_valid      = 1'b0;
        m_data       = '0;
        m_last       = 1'b0;
        forced_last  = (beat_cnt_q == LAST_BEAT);

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d           = XFER;
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    beat_cnt_d        = '0;
                end
            end

            XFER: begin
                // Pure pass-through; m_ready reaches only s_ready, never m_valid.
                m_valid          = own_valid;
                m_data           = own_data;
                m_last           = own_last | forced_last;
                s_ready[owner_q] = m_ready;
                if (own_valid && m_ready) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (own_last) begin
                        // Natural end, including exactly MAX_BEATS long.
                        pkt_count_d  = pkt_count_q + 16'd1;
                        last_grant_d = owner_q;
                        grant_d      = '0;
                        state_d      = IDLE;
                    end else if (forced_last) begin
                        // Truncated: downstream sees a complete packet.
                        pkt_count_d  = pkt_count_q + 16'd1;
                        err_d        = 1'b1;
                        last_grant_d = owner_q;
                        state_d      = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Swallow the tail of the oversize packet, keep the grant.
                s_ready[owner_q] = 1'b1;
                if (own_valid && own_last) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            grant_q      <= '0;
            last_grant_q <= IW'(N - 1);
            beat_cnt_q   <= '0;
            pkt_count_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_count_q  <= pkt_count_d;
            err_q        <= err_d;
        end
    end

    assign grant        = grant_q;
    assign busy         = (state_q != IDLE);
    assign pkt_count    = pkt_count_q;
    assign err_oversize = err_q;

    // Structural invariants of the controller.
    a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q));
    a_grant_idle : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE) |-> (grant_q == '0));
    a_beat_bound : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == XFER) |-> (beat_cnt_q <= LAST_BEAT));

endmodule

// File: tb/tb_udp_stream_arbiter.sv
// Directed bench for udp_stream_arbiter: one instance with the default
// MAX_BEATS=16 and one with MAX_BEATS=4 share the source-side stimulus; the
// instance not under test is held in reset and a select picks its outputs.
module tb_udp_stream_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst16_n, rst4_n, use4;
    logic [N-1:0]    s_valid, s_last;
    logic [16*N-1:0] s_data;
    logic            m_ready;

    logic [N-1:0] s_ready16, grant16, s_ready4, grant4;
    logic         m_valid16, m_last16, busy16, err16;
    logic         m_valid4, m_last4, busy4, err4;
    logic [15:0]  m_data16, pkt16, m_data4, pkt4;

    logic [N-1:0] c_s_ready, c_grant;
    logic         c_m_valid, c_m_last, c_busy, c_err;
    logic [15:0]  c_m_data, c_pkt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    udp_stream_arbiter #(.N(N), .MAX_BEATS(16)) dut16 (
        .clk(clk), .rst_n(rst16_n),
        .s_valid(s_valid), .s_ready(s_ready16), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid16), .m_ready(m_ready), .m_data(m_data16), .m_last(m_last16),
        .grant(grant16), .busy(busy16), .pkt_count(pkt16), .err_oversize(err16)
    );

    udp_stream_arbiter #(.N(N), .MAX_BEATS(4)) dut4 (
        .clk(clk), .rst_n(rst4_n),
        .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .m_last(m_last4),
        .grant(grant4), .busy(busy4), .pkt_count(pkt4), .err_oversize(err4)
    );

    assign c_s_ready = use4 ? s_ready4 : s_ready16;
    assign c_grant   = use4 ? grant4   : grant16;
    assign c_m_valid = use4 ? m_valid4 : m_valid16;
    assign c_m_last  = use4 ? m_last4  : m_last16;
    assign c_busy    = use4 ? busy4    : busy16;
    assign c_err     = use4 ? err4     : err16;
    assign c_m_data  = use4 ? m_data4  : m_data16;
    assign c_pkt     = use4 ? pkt4     : pkt16;

    typedef struct {
        logic [3:0]  sv;
        logic [63:0] sd;
        logic [3:0]  sl;
        logic        mr;
        logic        e_mv;
        logic [15:0] e_md;
        logic        e_ml;
        logic [3:0]  e_gr;
        logic        e_busy;
        logic [3:0]  e_sr;
        logic [15:0] e_pkt;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Source s carries word d; the other lanes carry distinct filler.
    function automatic logic [63:0] pk(input int s, input logic [15:0] d);
        logic [63:0] r;
        for (int j = 0; j < N; j++) r[16*j +: 16] = (j == s) ? d : 16'(16'hEE00 + j);
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] sv, input logic [63:0] sd, input logic [3:0] sl,
                                input logic mr, input logic mv, input logic [15:0] md, input logic ml,
                                input logic [3:0] gr, input logic bz, input logic [3:0] sr,
                                input logic [15:0] pc, input logic er);
        vec_t v;
        v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
        v.e_mv = mv; v.e_md = md; v.e_ml = ml; v.e_gr = gr;
        v.e_busy = bz; v.e_sr = sr; v.e_pkt = pc; v.e_err = er;
        return v;
    endfunction

    task automatic run_table(input int lo, input int hi, input string tag);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            s_valid = vecs[i].sv;
            s_data  = vecs[i].sd;
            s_last  = vecs[i].sl;
            m_ready = vecs[i].mr;
            #1;
            check($sformatf("%s[%0d].m_valid", tag, i), c_m_valid, vecs[i].e_mv);
            check($sformatf("%s[%0d].m_data", tag, i), c_m_data, vecs[i].e_md);
            check($sformatf("%s[%0d].m_last", tag, i), c_m_last, vecs[i].e_ml);
            check($sformatf("%s[%0d].grant", tag, i), c_grant, vecs[i].e_gr);
            check($sformatf("%s[%0d].busy", tag, i), c_busy, vecs[i].e_busy);
            check($sformatf("%s[%0d].s_ready", tag, i), c_s_ready, vecs[i].e_sr);
            check($sformatf("%s[%0d].pkt_count", tag, i), c_pkt, vecs[i].e_pkt);
            check($sformatf("%s[%0d].err", tag, i), c_err, vecs[i].e_err);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".m_valid"}, c_m_valid, 0);
        check({tag, ".m_data"}, c_m_data, 0);
        check({tag, ".m_last"}, c_m_last, 0);
        check({tag, ".grant"}, c_grant, 0);
        check({tag, ".busy"}, c_busy, 0);
        check({tag, ".s_ready"}, c_s_ready, 0);
        check({tag, ".pkt_count"}, c_pkt, 0);
        check({tag, ".err"}, c_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bi [N];
        int exp_order [6];
        int pkts;
        int cyc;
        int g;
        logic [3:0] eg;

        // ---- vector tables ----
        // dut16: single source 0, four beats, then bubble.
        vecs.push_back(mk(4'b0001, pk(0, 16'h1111), 4'b0000, 1, 0, 16'h0000, 0, 4'b0000, 0, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0001, pk(0, 16'h1111), 4'b0000, 1, 1, 16'h1111, 0, 4'b0001, 1, 4'b0001, 0, 0));
        vecs.push_back(mk(4'b0001, pk(0, 16'h2222), 4'b0000, 1, 1, 16'h2222, 0, 4'b0001, 1, 4'b0001, 0, 0));
        vecs.push_back(mk(4'b0001, pk(0, 16'h3333), 4'b0000, 1, 1, 16'h3333, 0, 4'b0001, 1, 4'b0001, 0, 0));
        vecs.push_back(mk(4'b0001, pk(0, 16'h4444), 4'b0001, 1, 1, 16'h4444, 1, 4'b0001, 1, 4'b0001, 0, 0));
        vecs.push_back(mk(4'b0000, pk(0, 16'h0000), 4'b0000, 1, 0, 16'h0000, 0, 4'b0000, 0, 4'b0000, 1, 0));
        // dut16: source 1, five beats under backpressure (idx 6..18).
        vecs.push_back(mk(4'b0010, pk(1, 16'hA001), 4'b0000, 1, 0, 16'h0000, 0, 4'b0000, 0, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0010, pk(1, 16'hA001), 4'b0000, 1, 1, 16'hA001, 0, 4'b0010, 1, 4'b0010, 1, 0));
        vecs.push_back(mk(4'b0010, pk(1, 16'hA002), 4'b0000, 0, 1, 16'hA002, 0, 4'b0010, 1, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0010, pk(1, 16'hA002), 4'b0000, 0, 1, 16'hA002, 0, 4'b0010, 1, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0010, pk(1, 16'hA002), 4'b0000, 1, 1, 16'hA002, 0, 4'b0010, 1, 4'b0010, 1, 0));
        vecs.push_back(mk(4'b0010, pk(1, 16'hA003), 4'b0000, 0, 1, 16'hA003, 0, 4'b0010, 1, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0010, pk(1, 16'hA003), 4'b0000, 0, 1, 16'hA003, 0, 4'b0010, 1, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0010, pk(1, 16'hA003), 4'b0000, 1, 1, 16'hA003, 0, 4'b0010, 1, 4'b0010, 1, 0));
        vecs.push_back(mk(4'b0010, pk(1, 16'hA004), 4'b0000, 0, 1, 16'hA004, 0, 4'b0010, 1, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0010, pk(1, 16'hA004), 4'b0000, 1, 1, 16'hA004, 0, 4'b0010, 1, 4'b0010, 1, 0));
        vecs.push_back(mk(4'b0010, pk(1, 16'hA005), 4'b0010, 0, 1, 16'hA005, 1, 4'b0010, 1, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0010, pk(1, 16'hA005), 4'b0010, 1, 1, 16'hA005, 1, 4'b0010, 1, 4'b0010, 1, 0));
        vecs.push_back(mk(4'b0000, pk(1, 16'h0000), 4'b0000, 1, 0, 16'h0000, 0, 4'b0000, 0, 4'b0000, 2, 0));
        // dut4: exact-length packet from source 2 (idx 19..24).
        vecs.push_back(mk(4'b0100, pk(2, 16'h3001), 4'b0000, 1, 0, 16'h0000, 0, 4'b0000, 0, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0100, pk(2, 16'h3001), 4'b0000, 1, 1, 16'h3001, 0, 4'b0100, 1, 4'b0100, 0, 0));
        vecs.push_back(mk(4'b0100, pk(2, 16'h3002), 4'b0000, 1, 1, 16'h3002, 0, 4'b0100, 1, 4'b0100, 0, 0));
        vecs.push_back(mk(4'b0100, pk(2, 16'h3003), 4'b0000, 1, 1, 16'h3003, 0, 4'b0100, 1, 4'b0100, 0, 0));
        vecs.push_back(mk(4'b0100, pk(2, 16'h3004), 4'b0100, 1, 1, 16'h3004, 1, 4'b0100, 1, 4'b0100, 0, 0));
        vecs.push_back(mk(4'b0000, pk(2, 16'h0000), 4'b0000, 1, 0, 16'h0000, 0, 4'b0000, 0, 4'b0000, 1, 0));
        // dut4: 7-beat oversize packet from source 2 (idx 25..34).
        vecs.push_back(mk(4'b0100, pk(2, 16'h2001), 4'b0000, 1, 0, 16'h0000, 0, 4'b0000, 0, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0100, pk(2, 16'h2001), 4'b0000, 1, 1, 16'h2001, 0, 4'b0100, 1, 4'b0100, 1, 0));
        vecs.push_back(mk(4'b0100, pk(2, 16'h2002), 4'b0000, 1, 1, 16'h2002, 0, 4'b0100, 1, 4'b0100, 1, 0));
        vecs.push_back(mk(4'b0100, pk(2, 16'h2003), 4'b0000, 1, 1, 16'h2003, 0, 4'b0100, 1, 4'b0100, 1, 0));
        vecs.push_back(mk(4'b0100, pk(2, 16'h2004), 4'b0000, 1, 1, 16'h2004, 1, 4'b0100, 1, 4'b0100, 1, 0));
        vecs.push_back(mk(4'b0100, pk(2, 16'h2005), 4'b0000, 0, 0, 16'h0000, 0, 4'b0100, 1, 4'b0100, 2, 1));
        vecs.push_back(mk(4'b0100, pk(2, 16'h2006), 4'b0000, 0, 0, 16'h0000, 0, 4'b0100, 1, 4'b0100, 2, 1));
        vecs.push_back(mk(4'b0100, pk(2, 16'h2007), 4'b0100, 1, 0, 16'h0000, 0, 4'b0100, 1, 4'b0100, 2, 1));
        vecs.push_back(mk(4'b0000, pk(2, 16'h0000), 4'b0000, 1, 0, 16'h0000, 0, 4'b0000, 0, 4'b0000, 2, 1));
        vecs.push_back(mk(4'b0000, pk(2, 16'h0000), 4'b0000, 1, 0, 16'h0000, 0, 4'b0000, 0, 4'b0000, 2, 1));

        // ---- reset ----
        use4    = 1'b0;
        rst16_n = 1'b0;
        rst4_n  = 1'b0;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("reset16");
        @(negedge clk);
        rst16_n = 1'b1;

        run_table(0, 19, "single_bp");

        // ---- round robin among sources 0, 1, 3 ----
        @(negedge clk);
        rst16_n = 1'b0;
        s_valid = '0;
        @(negedge clk);
        rst16_n = 1'b1;
        exp_order = '{0, 1, 3, 0, 1, 3};
        for (int i = 0; i < N; i++) bi[i] = 0;
        pkts = 0;
        cyc  = 0;
        while (pkts < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            s_valid = 4'b1011;
            m_ready = 1'b1;
            for (int i = 0; i < N; i++) begin
                s_data[16*i +: 16] = 16'(32'hC000 + i * 16 + bi[i]);
                s_last[i]          = (bi[i] == 1);
            end
            #1;
            if (c_m_valid && m_ready) begin
                g     = exp_order[pkts];
                eg    = '0;
                eg[g] = 1'b1;
                check($sformatf("rr[%0d].grant", pkts), c_grant, eg);
                check($sformatf("rr[%0d].data", pkts), c_m_data, 16'(32'hC000 + g * 16 + bi[g]));
                check($sformatf("rr[%0d].last", pkts), c_m_last, (bi[g] == 1));
                for (int i = 0; i < N; i++) begin
                    if (c_s_ready[i] && s_valid[i]) begin
                        if (bi[i] == 1) begin
                            bi[i] = 0;
                            pkts++;
                        end else begin
                            bi[i]++;
                        end
                    end
                end
            end
        end
        check("rr.packets", pkts, 6);
        check("rr.cycles", cyc, 18);
        @(negedge clk);
        s_valid = '0;
        s_last  = '0;
        #1;
        check("rr.pkt_count", c_pkt, 6);
        check("rr.busy", c_busy, 0);

        // ---- reset in the middle of a 5-beat packet from source 0 ----
        @(negedge clk);
        s_valid = 4'b0001;
        s_data  = pk(0, 16'h5001);
        #1;
        check("mid.idle_busy", c_busy, 0);
        @(negedge clk);
        #1;
        check("mid.beat1", c_m_data, 16'h5001);
        check("mid.grant", c_grant, 4'b0001);
        @(negedge clk);
        s_data = pk(0, 16'h5002);
        #1;
        check("mid.beat2", c_m_data, 16'h5002);
        check("mid.pkt_before", c_pkt, 6);
        @(negedge clk);
        rst16_n = 1'b0;
        s_data  = pk(0, 16'h5003);
        @(negedge clk);
        rst16_n = 1'b1;
        s_valid = 4'b0010;
        s_data  = pk(1, 16'h6001);
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        #1;
        check("mid.regrant", c_grant, 4'b0010);
        check("mid.regrant_busy", c_busy, 1);
        check("mid.regrant_data", c_m_data, 16'h6001);
        check("mid.regrant_pkt", c_pkt, 0);

        // ---- MAX_BEATS=4 instance: exact length, then oversize ----
        @(negedge clk);
        rst16_n = 1'b0;
        s_valid = '0;
        s_last  = '0;
        use4    = 1'b1;
        #1;
        check_reset_state("reset4");
        rst4_n = 1'b1;
        run_table(19, 35, "max4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
